// File: rtl/ttt_move_driver.sv
// ttt_move_driver
//   Move-issuing front end for the tic-tac-toe engine. Queued moves are
//   pre-validated against a shadow board, then presented to the engine for
//   exactly one cycle in step with its WAIT_MOVE/CHECK cadence. When the engine
//   reports game end, the result is latched and the driver parks in D_DONE.
// Ports
//   clk, reset        : clock, async active-high reset (shared with engine)
//   start             : begin game (sampled in D_IDLE only)
//   move_valid/ready  : push handshake; move_x/move_y/move_player payload
//   stop_game, winner : engine status in
//   enable            : one-cycle start pulse to engine
//   data_in_x/y,player: move presented to engine (player 3 = idle slot)
//   reject            : pulse when a popped move is dropped as illegal
//   moves_issued      : committed move count (saturating)
//   game_over, result : sticky end flag and latched winner (3 = draw)
module ttt_move_driver #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move_x,
  input  logic [1:0] move_y,
  input  logic [1:0] move_player,
  output logic       move_ready,
  input  logic       stop_game,
  input  logic [1:0] winner,
  output logic       enable,
  output logic [1:0] data_in_x,
  output logic [1:0] data_in_y,
  output logic [1:0] player,
  output logic       reject,
  output logic [3:0] moves_issued,
  output logic       game_over,
  output logic [1:0] result
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {D_IDLE, D_ARM, D_WAIT, D_CHECK, D_DONE} state_t;

  state_t                 state_q, state_d;
  logic [DEPTH-1:0][5:0]  mem_q;
  logic [AW:0]            wr_q, rd_q;
  logic [8:0][1:0]        board_q, board_d;
  logic [1:0]             last_q, last_d;
  logic                   enable_q, enable_d;
  logic [1:0]             x_q, x_d, y_q, y_d, player_q, player_d;
  logic                   reject_q, reject_d;
  logic [3:0]             moves_q, moves_d;
  logic                   go_q, go_d;
  logic [1:0]             result_q, result_d;

  logic       empty, full, push, pop, legal;
  logic [5:0] head;
  logic [1:0] hx, hy, hp, head_cell;
  logic [3:0] hidx, widx;

  // Extra pointer bit separates full from empty when the low bits match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign move_ready = !full && (state_q != D_DONE);
  assign push  = move_valid && move_ready;

  assign head = mem_q[rd_q[AW-1:0]];
  assign hx   = head[5:4];
  assign hy   = head[3:2];
  assign hp   = head[1:0];
  assign hidx = {2'b00, hy} * 4'd3 + {2'b00, hx};
  assign widx = {2'b00, y_q} * 4'd3 + {2'b00, x_q};

  // An out-of-range head may alias a real cell index; the range terms in
  // 'legal' make that lookup irrelevant.
  always_comb begin
    head_cell = 2'd3;
    for (int i = 0; i < 9; i++)
      if (hidx == 4'(i)) head_cell = board_q[i];
  end

  assign legal = (hp <= 2'd1) && (hp != last_q) && (hx <= 2'd2) &&
                 (hy <= 2'd2) && (head_cell == 2'd3);

  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    player_d = 2'd3;
    reject_d = 1'b0;
    moves_d  = moves_q;
    go_d     = go_q;
    result_d = result_q;
    board_d  = board_q;
    last_d   = last_q;
    pop      = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (start) begin
          state_d  = D_ARM;
          enable_d = 1'b1;
        end
      end
      // Slot load: the popped move is shown during the following D_WAIT.
      D_ARM, D_CHECK: begin
        state_d = D_WAIT;
        if (!empty) begin
          pop = 1'b1;
          if (legal) begin
            x_d      = hx;
            y_d      = hy;
            player_d = hp;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      D_WAIT: begin
        if (stop_game) begin
          // Engine already ended; the move on the bus is not committed.
          result_d = winner;
          go_d     = 1'b1;
          state_d  = D_DONE;
        end else begin
          if (player_q != 2'd3) begin
            for (int i = 0; i < 9; i++)
              if (widx == 4'(i)) board_d[i] = player_q;
            last_d = player_q;
            if (moves_q != 4'hf) moves_d = moves_q + 4'd1;
          end
          state_d = D_CHECK;
        end
      end
      D_DONE: ;
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= D_IDLE;
      mem_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      board_q  <= {9{2'd3}};
      last_q   <= 2'd3;
      enable_q <= 1'b0;
      x_q      <= 2'd0;
      y_q      <= 2'd0;
      player_q <= 2'd3;
      reject_q <= 1'b0;
      moves_q  <= 4'd0;
      go_q     <= 1'b0;
      result_q <= 2'd3;
    end else begin
      state_q  <= state_d;
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= {move_x, move_y, move_player};
        wr_q <= wr_q + PTR_ONE;
      end
      if (pop) rd_q <= rd_q + PTR_ONE;
      board_q  <= board_d;
      last_q   <= last_d;
      enable_q <= enable_d;
      x_q      <= x_d;
      y_q      <= y_d;
      player_q <= player_d;
      reject_q <= reject_d;
      moves_q  <= moves_d;
      go_q     <= go_d;
      result_q <= result_d;
    end
  end

  assign enable       = enable_q;
  assign data_in_x    = x_q;
  assign data_in_y    = y_q;
  assign player       = player_q;
  assign reject       = reject_q;
  assign moves_issued = moves_q;
  assign game_over    = go_q;
  assign result       = result_q;

endmodule

// File: tb/tb_ttt_move_driver.sv
// tb_ttt_move_driver
//   Stimulus pushes moves and feeds a rule-level game model that predicts each
//   slot (issue or reject) into a scoreboard queue. A separate negedge process
//   plays the engine (WAIT/CHECK cadence, win/draw detection, stop_game), pops
//   and compares every presented slot, and services end-of-scenario checks.
module tb_ttt_move_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_x = 2'd0, move_y = 2'd0, move_player = 2'd0;
  logic       move_ready;
  logic       stop_game = 1'b0;
  logic [1:0] winner = 2'd3;
  logic       enable;
  logic [1:0] data_in_x, data_in_y, player;
  logic       reject;
  logic [3:0] moves_issued;
  logic       game_over;
  logic [1:0] result;

  ttt_move_driver #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .move_x(move_x), .move_y(move_y), .move_player(move_player),
    .move_ready(move_ready), .stop_game(stop_game), .winner(winner),
    .enable(enable), .data_in_x(data_in_x), .data_in_y(data_in_y),
    .player(player), .reject(reject), .moves_issued(moves_issued),
    .game_over(game_over), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit rej; int x; int y; int p; } exp_t;
  typedef struct { int kind; int a; } req_t;
  localparam int K_FINAL = 1, K_SLOTS = 2, K_NOTREADY = 3, K_READY = 4;

  exp_t exp_q[$];
  req_t req_q[$];
  int   n_pass = 0, n_tot = 0;

  int LN[24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

  // 0/1 = that player has a line, 3 = full board with no line, 2 = still open
  function automatic int line_result(input int b[9]);
    for (int l = 0; l < 8; l++)
      if (b[LN[3*l]] != 3 && b[LN[3*l]] == b[LN[3*l+1]] && b[LN[3*l]] == b[LN[3*l+2]])
        return b[LN[3*l]];
    for (int i = 0; i < 9; i++) if (b[i] == 3) return 2;
    return 3;
  endfunction

  // ---------------- reference model (stimulus side) ----------------
  int m_b[9];
  int m_last, m_cnt, m_ended, m_winner, m_rej;
  int start_cyc = 0;
  int sx[$], sy[$], sp[$];

  task automatic model_clear();
    foreach (m_b[i]) m_b[i] = 3;
    m_last = 3; m_cnt = 0; m_ended = 0; m_winner = 3; m_rej = 0;
  endtask

  // Slots are consumed in FIFO order, so each accepted move's fate follows
  // from the moves accepted before it.
  task automatic model_push(input int x, input int y, input int p);
    exp_t e;
    bit lg;
    int r;
    lg = (p <= 1) && (p != m_last) && (x <= 2) && (y <= 2);
    if (lg) lg = (m_b[y*3+x] == 3);
    e.rej = !lg; e.x = x; e.y = y; e.p = p;
    exp_q.push_back(e);
    if (!m_ended) begin
      if (lg) begin
        m_b[y*3+x] = p; m_last = p; m_cnt++;
        r = line_result(m_b);
        if (r != 2) begin m_ended = 1; m_winner = r; end
      end else m_rej++;
    end
  endtask

  task automatic send_req(input int k, input int a);
    req_t r;
    r.kind = k; r.a = a;
    req_q.push_back(r);
  endtask

  // ---------------- engine + monitor ----------------
  typedef enum {E_IDLE, E_WAIT, E_CHECK, E_DONE} es_t;
  es_t es = E_IDLE;
  int  e_b[9];
  int  e_end = 0, e_w = 3, rej_cnt = 0;
  int  slot_cyc[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic pop_cmp(input bit is_rej);
    exp_t e;
    chk("sb_entry_available", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(is_rej ? "slot_is_reject" : "slot_is_issue", int'(e.rej), int'(is_rej));
      if (!is_rej) begin
        chk("issue_x", int'(data_in_x), e.x);
        chk("issue_y", int'(data_in_y), e.y);
        chk("issue_player", int'(player), e.p);
      end
    end
  endtask

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      #1;
      chk("rst_enable", int'(enable), 0);
      chk("rst_player", int'(player), 3);
      chk("rst_x", int'(data_in_x), 0);
      chk("rst_y", int'(data_in_y), 0);
      chk("rst_move_ready", int'(move_ready), 1);
      chk("rst_reject", int'(reject), 0);
      chk("rst_moves_issued", int'(moves_issued), 0);
      chk("rst_game_over", int'(game_over), 0);
      chk("rst_result", int'(result), 3);
      es = E_IDLE; stop_game = 1'b0; winner = 2'd3;
      e_end = 0; e_w = 3; rej_cnt = 0;
      foreach (e_b[i]) e_b[i] = 3;
      exp_q.delete(); slot_cyc.delete();
    end else begin
      es_t nes;
      int  r;
      nes = es;
      while (req_q.size() > 0) begin
        req_t q;
        q = req_q.pop_front();
        case (q.kind)
          K_FINAL: begin
            chk("game_over", int'(game_over), m_ended);
            chk("moves_issued", int'(moves_issued), m_cnt);
            if (m_ended != 0) chk("result", int'(result), m_winner);
            else begin
              chk("reject_count", rej_cnt, m_rej);
              chk("sb_leftover", exp_q.size(), 0);
            end
          end
          K_SLOTS: begin
            chk("slot_count", int'(slot_cyc.size() >= q.a), 1);
            for (int i = 0; i < q.a && i < slot_cyc.size(); i++)
              chk("slot_cycle", slot_cyc[i] - start_cyc, 2 + 2*i);
          end
          K_NOTREADY: chk("move_ready_full", int'(move_ready), 0);
          K_READY:    chk("move_ready_stuck", int'(move_ready), 1);
          default: ;
        endcase
      end
      if (enable) begin
        chk("enable_cycle", cyc - start_cyc, 1);
        chk("enable_from_idle", int'(es == E_IDLE), 1);
      end
      if (reject) begin
        rej_cnt++;
        slot_cyc.push_back(cyc);
        chk("reject_in_wait", int'(es == E_WAIT), 1);
        pop_cmp(1'b1);
      end
      case (es)
        E_IDLE: begin
          chk("idle_player", int'(player), 3);
          if (enable) nes = E_WAIT;
        end
        E_WAIT: begin
          if (player != 2'd3) begin
            slot_cyc.push_back(cyc);
            pop_cmp(1'b0);
          end
          if (e_end != 0) begin
            stop_game = 1'b1;
            winner = 2'(e_w);
            nes = E_DONE;
          end else begin
            if (player != 2'd3 && data_in_x <= 2'd2 && data_in_y <= 2'd2) begin
              e_b[int'(data_in_y)*3 + int'(data_in_x)] = int'(player);
              r = line_result(e_b);
              if (r != 2) begin e_end = 1; e_w = r; end
            end
            nes = E_CHECK;
          end
        end
        E_CHECK: begin
          chk("check_player", int'(player), 3);
          nes = E_WAIT;
        end
        E_DONE: begin
          chk("done_player", int'(player), 3);
          chk("done_move_ready", int'(move_ready), 0);
          chk("done_enable", int'(enable), 0);
        end
        default: ;
      endcase
      es = nes;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset_now();
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    model_clear();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input int x, input int y, input int p, output bit ok);
    int b;
    b = 0;
    @(negedge clk);
    move_valid = 1'b1;
    move_x = 2'(x); move_y = 2'(y); move_player = 2'(p);
    while (!move_ready && !game_over && b < 40) begin
      @(negedge clk);
      b++;
    end
    ok = move_ready;
    if (ok) model_push(x, y, p);
    else if (!game_over) send_req(K_READY, 1);
    @(posedge clk);
    #1 move_valid = 1'b0;
  endtask

  task automatic finish_game(input int nslots);
    int b;
    b = 0;
    if (m_ended != 0) begin
      while (!game_over && b < 100) begin
        @(negedge clk);
        b++;
      end
    end else repeat (30) @(negedge clk);
    if (nslots > 0) send_req(K_SLOTS, nslots);
    send_req(K_FINAL, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_game(input int npre, input int gapmax, input int nslots, input bit rst);
    bit ok;
    if (rst) begin
      @(negedge clk);
      do_reset_now();
    end
    for (int i = 0; i < sx.size(); i++) begin
      if (i == npre) start_pulse();
      if (game_over) break;
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      push(sx[i], sy[i], sp[i], ok);
    end
    if (npre >= sx.size()) start_pulse();
    finish_game(nslots);
  endtask

  task automatic clr_moves();
    sx.delete(); sy.delete(); sp.delete();
  endtask

  task automatic add(input int x, input int y, input int p);
    sx.push_back(x); sy.push_back(y); sp.push_back(p);
  endtask

  initial begin
    bit ok5;
    int x, y, p, nextp;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    model_clear();

    // first move
    clr_moves(); add(0,0,0);
    run_game(1, 0, 1, 1'b1);

    // row win for player 0 along y=0
    clr_moves(); add(0,0,0); add(0,1,1); add(1,0,0); add(1,1,1); add(2,0,0);
    run_game(4, 0, 5, 1'b1);

    // repeat player, occupied cell, out of range
    clr_moves(); add(0,0,0); add(1,1,0); add(0,0,1); add(3,0,1);
    run_game(4, 0, 4, 1'b1);

    // draw
    clr_moves();
    add(0,0,0); add(1,0,1); add(2,0,0); add(1,1,1); add(0,1,0);
    add(2,1,1); add(1,2,0); add(0,2,1); add(2,2,0);
    run_game(4, 0, 9, 1'b1);

    // FIFO full: four accepted, fifth held until the first pop
    clr_moves();
    @(negedge clk);
    do_reset_now();
    push(0,0,0,ok5); push(1,0,1,ok5); push(0,1,0,ok5); push(1,1,1,ok5);
    send_req(K_NOTREADY, 0);
    fork
      push(0,2,0,ok5);
      begin
        repeat (2) begin
          @(negedge clk);
          send_req(K_NOTREADY, 0);
        end
        start_pulse();
      end
    join
    finish_game(4);

    // reset between edges during D_CHECK, then replay the first-move timing
    @(negedge clk);
    do_reset_now();
    push(0,0,0,ok5); push(1,1,1,ok5);
    start_pulse();
    repeat (2) @(negedge clk);
    do_reset_now();
    clr_moves(); add(0,0,0);
    run_game(1, 0, 1, 1'b0);

    // randomized games
    for (int g = 0; g < 8; g++) begin
      clr_moves();
      nextp = 0;
      for (int k = 0; k < 14; k++) begin
        x = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
        y = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
        p = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : nextp;
        if (p <= 1) nextp = 1 - p;
        add(x, y, p);
      end
      run_game(int'($urandom_range(0, 4)), 3, 0, 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ttt_move_driver.md
# ttt_move_driver

Move-issuing front end for the tic-tac-toe game engine. It accepts queued moves over a ready/valid push interface and pre-validates each one against a shadow copy of the board. Legal moves are presented on the engine's `data_in_x`/`data_in_y`/`player` inputs, aligned to the engine's two-cycle WAIT_MOVE/CHECK cadence. When the engine raises `stop_game`, the driver latches the game result.

## Interface
- `DEPTH`, default 4: move FIFO depth, a power of 2 and at least 2.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears every register immediately. Shared with the game engine.
- `start` in 1: request to begin the game; sampled only in D_IDLE.
- `move_valid` in 1: a push is offered.
- `move_x`, `move_y` in 2: target cell column and row.
- `move_player` in 2: mover ID; 0 or 1 are legal.
- `move_ready` out 1: push accepted when `move_valid && move_ready`.
- `stop_game` in 1: from the engine.
- `winner` in 2: from the engine; 0 or 1 is a win, 3 is a draw.
- `enable` out 2→1: to the engine; one-cycle start pulse.
- `data_in_x`, `data_in_y` out 2: to the engine.
- `player` out 2: to the engine; 3 marks an idle slot, which the engine ignores.
- `reject` out 1: one-cycle pulse when a queued move is dropped as illegal.
- `moves_issued` out 4: count of moves committed to the engine.
- `game_over` out 1: sticky once the game has ended.
- `result` out 2: engine `winner` latched at game end.

## Operation
- **States:** D_IDLE → D_ARM → D_WAIT ⇄ D_CHECK; D_WAIT → D_DONE. D_WAIT and D_CHECK mirror the engine's S_WAIT_MOVE and S_CHECK one-for-one.
- **D_IDLE:**
  - `enable` = 0 and `player` = 3.
  - If `start` is high, go to D_ARM and register `enable` = 1.
- **D_ARM:**
  - `enable` = 1 for exactly this cycle.
  - Perform a slot load (below), then go to D_WAIT.
- **D_CHECK:**
  - Perform a slot load, then go to D_WAIT.
- **Slot load** (D_ARM or D_CHECK, into the output registers for the next cycle):
  - If the FIFO is empty, load `player` = 3.
  - If the FIFO is non-empty, pop the head.
  - If the head is legal, load its x, y and player.
  - If the head is illegal, load `player` = 3 and pulse `reject` in the next cycle.
- **Legality** of a move (all four must hold):
  - `move_player` ≤ 1.
  - `move_player` ≠ the last committed player (reset value 3).
  - x ≤ 2 and y ≤ 2.
  - The shadow cell is empty (3).
- **D_WAIT:**
  - If `stop_game` is high: the presented move is not committed and the shadow board is not updated. Latch `result` ← `winner`, set `game_over` = 1, and go to D_DONE.
  - Otherwise, if `player` ≠ 3: write the shadow cell [y][x] ← `player`, set the last committed player ← `player`, and increment `moves_issued` (saturating at 15).
  - Load `player` = 3 for D_CHECK, then go to D_CHECK.
- **D_DONE:**
  - `player` = 3, `enable` = 0, `move_ready` = 0.
  - Queued entries are not popped.
  - The only exit is `reset`.
- **FIFO:**
  - `move_ready = !full && state != D_DONE`.
  - No write bypass: an entry pushed in cycle n can be popped no earlier than cycle n+1.
  - Push and pop in the same cycle are allowed when the FIFO is not full.
  - Pointers wrap modulo DEPTH, with an extra bit for the full/empty distinction.
- **Reset values:**
  - `enable` 0, `data_in_x` 0, `data_in_y` 0, `player` 3.
  - `move_ready` 1, `reject` 0, `moves_issued` 0, `game_over` 0, `result` 3.
  - State D_IDLE, FIFO empty, shadow board all 3, last committed player 3.

## Timing
- All outputs except `move_ready` are registered. `move_ready` is derived from registers only.
- Let cycle 0 be the cycle in which `start` is sampled:
  - Cycle 1: D_ARM, `enable` = 1.
  - Cycle 2: first D_WAIT; the engine is in S_WAIT_MOVE and samples the move.
  - Cycle 3: D_CHECK.
  - Cycle 4: next D_WAIT, and so on.
- A move is held on the engine inputs for exactly one cycle, the D_WAIT cycle; `player` is 3 in all other cycles.
- At most one move is issued per two cycles. An empty FIFO in D_ARM or D_CHECK produces an idle slot.
- `stop_game` is first visible in the D_WAIT that follows the winning D_CHECK. `game_over` and `result` are valid one cycle later.
- Reset asserted mid-game: all outputs return to their reset values immediately, without waiting for a clock edge. The engine must be reset in the same cycle.

## Test plan
- **First move:**
  - Stimulus: push (0,0,p0), `start` in cycle 0.
  - Required: `enable` = 1 only in cycle 1; cycle 2 drives x0 y0 `player` 0; cycle 3 `player` = 3; `moves_issued` = 1.
- **Row win:**
  - Stimulus: push p0(0,0), p1(0,1), p0(1,0), p1(1,1), p0(2,0).
  - Required: engine `winner` = 0; `game_over` = 1; `result` = 0; `moves_issued` = 5; `player` stays 3 afterwards.
- **Illegal moves:**
  - Stimulus: after p0(0,0), push p0(1,1) (repeat player), then p1(0,0) (occupied), then p1(3,0) (out of range).
  - Required: three `reject` pulses; three idle slots with `player` = 3; `moves_issued` stays 1.
- **Draw:**
  - Stimulus: nine legal alternating moves with no line.
  - Required: `result` = 3, `game_over` = 1, `moves_issued` = 9.
- **FIFO full:**
  - Stimulus: DEPTH=4, no `start`, five pushes.
  - Required: `move_ready` = 0 after the 4th accept; the 5th is held. After `start`, moves issue in order at cycles 2, 4, 6, 8.
- **Reset mid-game:**
  - Stimulus: assert `reset` between clock edges during D_CHECK.
  - Required: immediate return to reset values; the next `start` replays the timing of the first-move scenario.
